// File: rtl/data_memory_block_pkg.sv
// Shared types and widths for the block-granular data memory behind the data cache.
package dmem_pkg;
  localparam int BLOCK_W      = 128;
  localparam int BLOCK_ADDR_W = 28;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/data_memory_block_if.sv
// Cache <-> memory block handshake: level requests held until MEM_BUSYWAIT drops.
interface data_memory_block_if;
  logic                                 MEM_READ;
  logic                                 MEM_WRITE;
  logic [dmem_pkg::BLOCK_ADDR_W-1:0]    MEM_BLOCK_ADDR;
  logic [dmem_pkg::BLOCK_W-1:0]         MEM_WRITE_IN;
  logic [dmem_pkg::BLOCK_W-1:0]         MEM_READ_OUT;
  logic                                 MEM_BUSYWAIT;

  modport master (
    output MEM_READ, MEM_WRITE, MEM_BLOCK_ADDR, MEM_WRITE_IN,
    input  MEM_READ_OUT, MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_BLOCK_ADDR, MEM_WRITE_IN,
    output MEM_READ_OUT, MEM_BUSYWAIT
  );
endinterface

// File: rtl/data_memory_block_array.sv
// Single-port synchronous block RAM; read data is registered and cleared by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [BLOCK_W-1:0]   wdata_i,
  output logic [BLOCK_W-1:0]   rdata_o
);
  logic [BLOCK_W-1:0] mem_q [2**ADDR_BITS];
  logic [BLOCK_W-1:0] rdata_q;

  // Storage is deliberately never reset; only the output register is.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory_block.sv
// Fixed-latency block memory: IDLE accepts a request, ACCESS counts LATENCY cycles
// and commits on the last one, RESP drops BUSYWAIT for exactly one cycle.
module data_memory_block
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  data_memory_block_if.slave mem
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [BLOCK_W-1:0]     wdata_q, wdata_d;

  logic                   req;
  logic                   last;
  logic                   busy;
  logic                   we;
  logic                   re;
  logic [BLOCK_W-1:0]     rdata;
  logic                   unused_addr_hi;

  assign req            = mem.MEM_READ | mem.MEM_WRITE;
  assign last           = (state_q == ACCESS) && (cnt_q == LAST_CNT);
  assign unused_addr_hi = ^mem.MEM_BLOCK_ADDR[BLOCK_ADDR_W-1:ADDR_BITS];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latches only matter while in ACCESS, so they need no reset.
  always_ff @(posedge CLK) begin
    op_wr_q <= op_wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          op_wr_d = mem.MEM_WRITE;  // write wins over a simultaneous read
          addr_d  = mem.MEM_BLOCK_ADDR[ADDR_BITS-1:0];
          wdata_d = mem.MEM_WRITE_IN;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    we   = 1'b0;
    re   = 1'b0;
    case (state_q)
      IDLE:   busy = req;
      ACCESS: begin
        busy = 1'b1;
        we   = last &  op_wr_q;
        re   = last & ~op_wr_q;
      end
      default: busy = 1'b0;
    endcase
  end

  assign mem.MEM_BUSYWAIT = busy & RESET;
  assign mem.MEM_READ_OUT = rdata;

  dmem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk_i   (CLK),
    .rst_n_i (RESET),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );
endmodule

// File: tb/tb_data_memory_block.sv
// Directed bench for data_memory_block with a read-data scoreboard queue.
module tb_data_memory_block;
  localparam int LAT = 4;
  localparam int AB  = 8;

  localparam logic [127:0] DA5 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [127:0] D1  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D2  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D3  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] D4  = 128'h44444444_00000000_FFFFFFFF_44444444;
  localparam logic [127:0] D5  = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
  localparam logic [127:0] D6  = 128'h66666666_66666666_00000000_00000066;
  localparam logic [127:0] D7  = 128'h77777777_77777777_77777777_77777777;
  localparam logic [127:0] D8  = 128'h88888888_00000001_80000000_00000008;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_block_if bus ();

  data_memory_block #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .mem   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [127:0] model [256];
  logic [127:0] exp_q [$];
  logic [127:0] last_rd;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at #1 after a posedge (cycle 0); returns at #1 after the posedge ending RESP.
  task automatic access(input bit wr, input bit rd, input logic [27:0] a,
                        input logic [127:0] d, input string tag, input bit perturb);
    int n;
    logic [127:0] e;
    bus.MEM_WRITE      = wr;
    bus.MEM_READ       = rd;
    bus.MEM_BLOCK_ADDR = a;
    bus.MEM_WRITE_IN   = d;
    if (wr) model[a[AB-1:0]] = d;
    else    exp_q.push_back(model[a[AB-1:0]]);
    @(negedge clk);
    check({tag, ".busy_same_cycle"}, 128'(bus.MEM_BUSYWAIT), 128'(1));
    n = 0;
    while (bus.MEM_BUSYWAIT !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
      if (perturb && n == 2) begin
        bus.MEM_WRITE      = 1'b0;
        bus.MEM_READ       = 1'b0;
        bus.MEM_BLOCK_ADDR = a ^ 28'h1;
        bus.MEM_WRITE_IN   = ~d;
      end
    end
    check({tag, ".busy_low_cycle"}, 128'(n), 128'(LAT + 1));
    if (wr) begin
      check({tag, ".rdout_unchanged"}, bus.MEM_READ_OUT, last_rd);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".rdata"}, bus.MEM_READ_OUT, e);
      last_rd = e;
    end
    @(posedge clk);
    #1;
    bus.MEM_WRITE = 1'b0;
    bus.MEM_READ  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.MEM_READ       = 1'b1;
    bus.MEM_WRITE      = 1'b0;
    bus.MEM_BLOCK_ADDR = '0;
    bus.MEM_WRITE_IN   = '0;
    last_rd            = '0;

    // Reset held with a read request pending
    repeat (3) @(negedge clk);
    check("rst.busy", 128'(bus.MEM_BUSYWAIT), 128'(0));
    check("rst.rdout", bus.MEM_READ_OUT, 128'(0));
    #2 rst_n = 1'b1;
    #1 check("rst.release_busy", 128'(bus.MEM_BUSYWAIT), 128'(1));
    bus.MEM_READ = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle.busy", 128'(bus.MEM_BUSYWAIT), 128'(0));
    @(posedge clk); #1;

    // Write then read back-to-back
    access(1'b1, 1'b0, 28'd3, DA5, "t2w", 1'b0);
    access(1'b0, 1'b1, 28'd3, '0,  "t2r", 1'b0);

    // Write-back then fill with no gap
    access(1'b1, 1'b0, 28'd2, D2, "t3pre", 1'b0);
    access(1'b1, 1'b0, 28'd7, D1, "t3w",   1'b0);
    access(1'b0, 1'b1, 28'd2, '0, "t3r2",  1'b0);
    access(1'b0, 1'b1, 28'd7, '0, "t3r7",  1'b0);

    // Aliasing modulo 2**AB
    access(1'b1, 1'b0, 28'h105,     D3, "t4w",   1'b0);
    access(1'b0, 1'b1, 28'h005,     '0, "t4r",   1'b0);
    access(1'b0, 1'b1, 28'hABCD005, '0, "t4rhi", 1'b0);

    // Inputs dropped / address changed mid-ACCESS
    access(1'b1, 1'b0, 28'd10, D5, "t5pre", 1'b0);
    access(1'b1, 1'b0, 28'd9,  D4, "t5w",   1'b1);
    access(1'b0, 1'b1, 28'd9,  '0, "t5r9",  1'b0);
    access(1'b0, 1'b1, 28'd10, '0, "t5r10", 1'b0);
    access(1'b0, 1'b1, 28'd9,  '0, "t5rp",  1'b1);

    // Simultaneous read and write: write wins
    access(1'b1, 1'b1, 28'd20, D8, "both",  1'b0);
    access(1'b0, 1'b1, 28'd20, '0, "bothr", 1'b0);

    // Reset pulse during a write ACCESS aborts the write
    access(1'b1, 1'b0, 28'd12, D6, "t6pre", 1'b0);
    bus.MEM_WRITE      = 1'b1;
    bus.MEM_BLOCK_ADDR = 28'd12;
    bus.MEM_WRITE_IN   = D7;
    @(negedge clk);
    check("t6.busy_accept", 128'(bus.MEM_BUSYWAIT), 128'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6.busy_in_reset", 128'(bus.MEM_BUSYWAIT), 128'(0));
    check("t6.rdout_in_reset", bus.MEM_READ_OUT, 128'(0));
    last_rd = '0;
    @(negedge clk);
    bus.MEM_WRITE = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6.idle_after", 128'(bus.MEM_BUSYWAIT), 128'(0));
    @(posedge clk); #1;
    access(1'b0, 1'b1, 28'd12, '0, "t6r", 1'b0);

    @(negedge clk);
    check("end.idle", 128'(bus.MEM_BUSYWAIT), 128'(0));
    check("end.rdout_hold", bus.MEM_READ_OUT, last_rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
